// File: rtl/fpu_pkg.sv
// Shared encodings, FSM states and format helpers for the iterative FP mul/div unit.
package fpu_pkg;

  localparam logic [1:0] FPU_MUL = 2'b00;
  localparam logic [1:0] FPU_DIV = 2'b01;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ITER,
    S_NORM,
    S_ROUND
  } state_t;

  // Canonical quiet NaN in the low 1+exp_w+man_w bits: sign 0, exp all-ones, frac MSB set.
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] e_ones;
    e_ones = (64'd1 << exp_w) - 64'd1;
    return (e_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational operand decode: fields, significand with hidden bit, class bits.
module fpu_classify #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       sig,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_nan,
  output logic                 is_snan,
  output logic                 is_sub
);

  logic [MAN_W-1:0] frac;
  logic             e_zero;
  logic             e_ones;

  assign sign    = x[EXP_W+MAN_W];
  assign exp     = x[EXP_W+MAN_W-1:MAN_W];
  assign frac    = x[MAN_W-1:0];
  assign e_zero  = (exp == '0);
  assign e_ones  = &exp;

  assign is_zero = e_zero && (frac == '0);
  assign is_sub  = e_zero && (frac != '0);
  assign is_inf  = e_ones && (frac == '0);
  assign is_nan  = e_ones && (frac != '0);
  assign is_snan = is_nan && !frac[MAN_W-1];
  // Subnormals carry no hidden bit and are treated as zero downstream.
  assign sig     = e_zero ? '0 : {1'b1, frac};

endmodule

// File: rtl/fpu_muldiv_iter.sv
// Iterative FP multiply/divide: bit-serial shift-add multiply, restoring divide,
// RNE rounding with flush-to-zero, fixed MAN_W+5 cycle latency.
module fpu_muldiv_iter
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [1:0]           fpu_op,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  output logic                 busy,
  output logic                 ack,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int M     = MAN_W + 1;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam int EW    = EXP_W + 2;

  localparam logic [CNT_W-1:0]    LAST   = CNT_W'(MAN_W + 1);
  localparam logic signed [EW-1:0] BIAS  = EW'(bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE = 1;
  localparam logic signed [EW-1:0] E_ZERO = 0;
  localparam logic [63:0]         QNAN64 = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]        QNAN   = QNAN64[W-1:0];

  state_t state, state_nx;

  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic           sgn_q;
  logic signed [EW-1:0] exp_q;
  logic [2*M-1:0] acc;       // product (mul) or partial remainder (div)
  logic [M:0]     qb;        // multiplier bits (mul) or quotient (div)
  logic [M-1:0]   dsig;      // addend (mul) or divisor (div)
  logic [CNT_W-1:0] cnt;
  logic [M-1:0]   n_sig;
  logic           n_g, n_s;
  logic           sp_hit;
  logic [W-1:0]   sp_res;
  logic [4:0]     sp_fl;

  logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf;
  logic             a_nan, b_nan, a_snan, b_snan, a_sub, b_sub;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [M-1:0]     a_sig, b_sig;

  fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x(a_q), .sign(a_sign), .exp(a_exp), .sig(a_sig), .is_zero(a_zero),
    .is_inf(a_inf), .is_nan(a_nan), .is_snan(a_snan), .is_sub(a_sub)
  );

  fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x(b_q), .sign(b_sign), .exp(b_exp), .sig(b_sig), .is_zero(b_zero),
    .is_inf(b_inf), .is_nan(b_nan), .is_snan(b_snan), .is_sub(b_sub)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req) state_nx = S_UNPACK;
      S_UNPACK: state_nx = S_ITER;
      S_ITER:   if (cnt == LAST) state_nx = S_NORM;
      S_NORM:   state_nx = S_ROUND;
      S_ROUND:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // ---------------- unpack / special cases ----------------
  logic                 sgn, za, zb, a_lt, hit;
  logic [W-1:0]         sp_res_nx, inf_v, zero_v;
  logic [4:0]           sp_fl_nx;
  logic signed [EW-1:0] exp_mul, exp_div;

  always_comb begin
    sgn     = a_sign ^ b_sign;
    za      = a_zero | a_sub;
    zb      = b_zero | b_sub;
    a_lt    = (a_sig < b_sig);
    inf_v   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    zero_v  = {sgn, {(W-1){1'b0}}};
    exp_mul = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
    // Dividend is pre-shifted when smaller so the quotient always lands in [1,2).
    exp_div = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS - (a_lt ? E_ONE : E_ZERO);

    hit       = 1'b1;
    sp_res_nx = QNAN;
    sp_fl_nx  = '0;
    if (op_q[1]) begin
      sp_fl_nx[FL_NV] = 1'b1;
    end else if (a_nan || b_nan) begin
      sp_fl_nx[FL_NV] = a_snan | b_snan;
    end else if (op_q == FPU_MUL) begin
      if ((za && b_inf) || (a_inf && zb)) sp_fl_nx[FL_NV] = 1'b1;
      else if (a_inf || b_inf)            sp_res_nx = inf_v;
      else if (za || zb)                  sp_res_nx = zero_v;
      else                                hit = 1'b0;
    end else begin
      if ((za && zb) || (a_inf && b_inf)) sp_fl_nx[FL_NV] = 1'b1;
      else if (a_inf)                     sp_res_nx = inf_v;
      else if (zb) begin
        sp_res_nx = inf_v;
        sp_fl_nx[FL_DZ] = 1'b1;
      end
      else if (b_inf || za)               sp_res_nx = zero_v;
      else                                hit = 1'b0;
    end
  end

  // ---------------- iteration datapath ----------------
  logic [M:0] rem, diff;
  logic       ge;

  always_comb begin
    rem  = acc[M:0];
    diff = rem - {1'b0, dsig};
    ge   = ~diff[M];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      sgn_q  <= 1'b0;
      exp_q  <= '0;
      acc    <= '0;
      qb     <= '0;
      dsig   <= '0;
      cnt    <= '0;
      n_sig  <= '0;
      n_g    <= 1'b0;
      n_s    <= 1'b0;
      sp_hit <= 1'b0;
      sp_res <= '0;
      sp_fl  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          a_q  <= op_a;
          b_q  <= op_b;
          op_q <= fpu_op;
        end
        S_UNPACK: begin
          sgn_q  <= sgn;
          sp_hit <= hit;
          sp_res <= sp_res_nx;
          sp_fl  <= sp_fl_nx;
          cnt    <= '0;
          if (op_q == FPU_DIV) begin
            exp_q <= exp_div;
            acc   <= a_lt ? {{(M-1){1'b0}}, a_sig, 1'b0} : {{M{1'b0}}, a_sig};
            qb    <= '0;
            dsig  <= b_sig;
          end else begin
            exp_q <= exp_mul;
            acc   <= '0;
            qb    <= {1'b0, b_sig};
            dsig  <= a_sig;
          end
        end
        S_ITER: begin
          cnt <= cnt + 1'b1;
          if (op_q == FPU_DIV) begin
            acc <= {{(M-1){1'b0}}, (ge ? diff[M-1:0] : rem[M-1:0]), 1'b0};
            qb  <= {qb[M-1:0], ge};
          end else if (cnt != LAST) begin
            // MSB-first shift-add; the last ITER cycle is left idle.
            acc <= (acc << 1) + (qb[M-1] ? {{M{1'b0}}, dsig} : '0);
            qb  <= qb << 1;
          end
        end
        S_NORM: begin
          if (op_q == FPU_DIV) begin
            n_sig <= qb[M:1];
            n_g   <= qb[0];
            n_s   <= |acc;
          end else if (acc[2*M-1]) begin
            n_sig <= acc[2*M-1:M];
            n_g   <= acc[M-1];
            n_s   <= |acc[M-2:0];
            exp_q <= exp_q + E_ONE;
          end else begin
            n_sig <= acc[2*M-2:M-1];
            n_g   <= acc[M-2];
            n_s   <= |acc[M-3:0];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- round / pack ----------------
  logic                 rnd_up;
  logic [M:0]           sum;
  logic signed [EW-1:0] exp_r;
  logic [MAN_W-1:0]     frac_r;
  logic [W-1:0]         res_nx;
  logic [4:0]           fl_nx;

  always_comb begin
    rnd_up = n_g & (n_s | n_sig[0]);
    sum    = {1'b0, n_sig} + {{M{1'b0}}, rnd_up};
    exp_r  = sum[M] ? exp_q + E_ONE : exp_q;
    frac_r = sum[M] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    res_nx = {sgn_q, exp_r[EXP_W-1:0], frac_r};
    fl_nx  = '0;
    if (sp_hit) begin
      res_nx = sp_res;
      fl_nx  = sp_fl;
    end else if (exp_r >= EMAX) begin
      res_nx        = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      fl_nx[FL_OF]  = 1'b1;
      fl_nx[FL_NX]  = 1'b1;
    end else if (exp_r < E_ONE) begin
      res_nx        = {sgn_q, {(W-1){1'b0}}};
      fl_nx[FL_UF]  = 1'b1;
      fl_nx[FL_NX]  = 1'b1;
    end else begin
      fl_nx[FL_NX]  = n_g | n_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack    <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      ack <= (state == S_ROUND);
      if (state == S_ROUND) begin
        result <= res_nx;
        flags  <= fl_nx;
      end
    end
  end

endmodule

// File: tb/tb_fpu_muldiv_iter.sv
// Directed and randomized checks of fpu_muldiv_iter against an exact-arithmetic reference.
module tb_fpu_muldiv_iter;

  localparam int LAT32 = 28;
  localparam int LAT16 = 15;
  localparam logic [31:0] QN  = 32'h7FC00000;
  localparam logic [31:0] INF = 32'h7F800000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  fpu_op;
  logic [31:0] op_a, op_b;
  logic        busy, ack;
  logic [31:0] result;
  logic [4:0]  flags;

  logic        h_req;
  logic [1:0]  h_fpu_op;
  logic [15:0] h_op_a, h_op_b;
  logic        h_busy, h_ack;
  logic [15:0] h_result;
  logic [4:0]  h_flags;

  int checks = 0;
  int failures = 0;

  fpu_muldiv_iter dut (
    .clk(clk), .rst(rst), .req(req), .fpu_op(fpu_op), .op_a(op_a), .op_b(op_b),
    .busy(busy), .ack(ack), .result(result), .flags(flags)
  );

  fpu_muldiv_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .req(h_req), .fpu_op(h_fpu_op), .op_a(h_op_a), .op_b(h_op_b),
    .busy(h_busy), .ack(h_ack), .result(h_result), .flags(h_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact reference: value = n * 2^k, rounded to 24 bits with RNE, then FTZ/overflow.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [4:0] f);
    int ea, eb, p, k, sh, e;
    logic [127:0] n, ma, mb, mask;
    logic [24:0] sig;
    bit s, g, st, za, zb, ia, ib, na, nb, sna, snb;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    za  = (ea == 0);
    zb  = (eb == 0);
    ia  = (ea == 255) && (a[22:0] == 0);
    ib  = (eb == 255) && (b[22:0] == 0);
    na  = (ea == 255) && (a[22:0] != 0);
    nb  = (eb == 255) && (b[22:0] != 0);
    sna = na && !a[22];
    snb = nb && !b[22];
    r = QN;
    f = 5'b0;
    if (op[1]) f = 5'b10000;
    else if (na || nb) f = (sna || snb) ? 5'b10000 : 5'b0;
    else if (op == 2'b00 && ((za && ib) || (ia && zb))) f = 5'b10000;
    else if (op == 2'b00 && (ia || ib)) r = {s, INF[30:0]};
    else if (op == 2'b00 && (za || zb)) r = {s, 31'h0};
    else if (op == 2'b01 && ((za && zb) || (ia && ib))) f = 5'b10000;
    else if (op == 2'b01 && ia) r = {s, INF[30:0]};
    else if (op == 2'b01 && zb) begin r = {s, INF[30:0]}; f = 5'b01000; end
    else if (op == 2'b01 && (ib || za)) r = {s, 31'h0};
    else begin
      ma = {104'h0, 1'b1, a[22:0]};
      mb = {104'h0, 1'b1, b[22:0]};
      if (op == 2'b00) begin
        n = ma * mb; st = 1'b0; k = (ea - 127) + (eb - 127) - 46;
      end else begin
        n = (ma << 64) / mb; st = ((ma << 64) % mb) != 0; k = ea - eb - 64;
      end
      p = 0;
      for (int i = 0; i < 128; i++) if (n[i]) p = i;
      sh   = p - 23;
      sig  = 25'(n >> sh);
      g    = n[sh-1];
      mask = (128'd1 << (sh - 1)) - 128'd1;
      st   = st || ((n & mask) != 0);
      e    = p + k + 127;
      if (g && (st || sig[0])) sig = sig + 25'd1;
      if (sig[24]) begin sig = sig >> 1; e++; end
      if (e >= 255)   begin r = {s, INF[30:0]}; f = 5'b00101; end
      else if (e < 1) begin r = {s, 31'h0};     f = 5'b00011; end
      else begin r = {s, 8'(e), sig[22:0]}; f = {4'b0, g | st}; end
    end
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 15))
      0: x[30:0] = '0;
      1: x[30:0] = {8'hFF, 23'h0};
      2: begin x[30:23] = 8'hFF; if (x[22:0] == 0) x[0] = 1'b1; end
      3: x[30:23] = 8'h00;
      4, 5, 6: ;
      default: x[30:23] = 8'(100 + $urandom_range(0, 54));
    endcase
    return x;
  endfunction

  // Issue one FP32 op at the next negedge; inputs are scrambled while busy.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [4:0] f, output int lat, output logic bsy);
    @(negedge clk);
    fpu_op = op; op_a = a; op_b = b; req = 1'b1;
    @(posedge clk); #1;
    bsy = busy;
    req = 1'b0; fpu_op = 2'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) break;
    end
    r = result;
    f = flags;
  endtask

  logic [31:0] r, er, a, b;
  logic [4:0]  f, ef;
  logic [1:0]  op;
  logic        bsy;
  int          lat, acks;

  initial begin
    rst = 1'b1; req = 1'b0; fpu_op = '0; op_a = '0; op_b = '0;
    h_req = 1'b0; h_fpu_op = '0; h_op_a = '0; h_op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", ack, 0);
    check("reset_busy", busy, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    @(negedge clk); rst = 1'b0;

    run32(2'b00, 32'h3FC00000, 32'h40000000, r, f, lat, bsy);
    check("mul_1p5x2_res", r, 32'h40400000);
    check("mul_1p5x2_flags", f, 0);
    check("mul_1p5x2_lat", lat, LAT32);
    check("mul_1p5x2_busy", bsy, 1);

    // issued during the previous ack cycle
    run32(2'b01, 32'h3F800000, 32'h40400000, r, f, lat, bsy);
    check("div_1_3_res", r, 32'h3EAAAAAB);
    check("div_1_3_flags", f, 5'b00001);
    check("b2b_accept_busy", bsy, 1);
    check("b2b_lat", lat, LAT32);

    run32(2'b01, 32'h3F800000, 32'h00000000, r, f, lat, bsy);
    check("div_by_zero_res", r, INF);
    check("div_by_zero_flags", f, 5'b01000);
    run32(2'b00, 32'h00000000, 32'h7F800000, r, f, lat, bsy);
    check("mul_0_inf_res", r, QN);
    check("mul_0_inf_flags", f, 5'b10000);
    check("mul_0_inf_lat", lat, LAT32);
    run32(2'b00, 32'h7F7FFFFF, 32'h40000000, r, f, lat, bsy);
    check("mul_ovf_res", r, INF);
    check("mul_ovf_flags", f, 5'b00101);
    run32(2'b00, 32'h00800000, 32'h3F000000, r, f, lat, bsy);
    check("mul_unf_res", r, 32'h0);
    check("mul_unf_flags", f, 5'b00011);
    run32(2'b11, 32'h3F800000, 32'h3F800000, r, f, lat, bsy);
    check("reserved_res", r, QN);
    check("reserved_flags", f, 5'b10000);
    check("reserved_lat", lat, LAT32);

    // req pulsed while busy must be dropped
    @(negedge clk);
    fpu_op = 2'b00; op_a = 32'h40400000; op_b = 32'h40400000; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("busy_after_accept", busy, 1);
    repeat (4) @(negedge clk);
    fpu_op = 2'b01; op_a = 32'h3F800000; op_b = 32'h00000000; req = 1'b1;
    @(negedge clk); req = 1'b0;
    acks = 0;
    r = '0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        if (acks == 1) r = result;
      end
    end
    check("busy_req_ack_count", acks, 1);
    check("busy_req_result", r, 32'h41100000);
    check("idle_busy", busy, 0);

    // reset in the middle of the iteration phase
    @(negedge clk);
    fpu_op = 2'b00; op_a = 32'h3FC00000; op_b = 32'h40000000; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ack", ack, 0);
    @(negedge clk); rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check("rst_mid_no_ack", acks, 0);
    check("rst_mid_result", result, 0);
    run32(2'b01, 32'h40400000, 32'h3F800000, r, f, lat, bsy);
    check("after_rst_res", r, 32'h40400000);
    check("after_rst_flags", f, 0);
    check("after_rst_lat", lat, LAT32);

    // half-precision instance
    @(negedge clk);
    h_fpu_op = 2'b00; h_op_a = 16'h3C00; h_op_b = 16'h4000; h_req = 1'b1;
    @(posedge clk); #1;
    h_req = 1'b0;
    check("h_busy", h_busy, 1);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (h_ack) break;
    end
    check("h_mul_res", h_result, 16'h4000);
    check("h_mul_flags", h_flags, 0);
    check("h_mul_lat", lat, LAT16);

    for (int t = 0; t < 60; t++) begin
      op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      a  = rnd_operand();
      b  = rnd_operand();
      model(op, a, b, er, ef);
      run32(op, a, b, r, f, lat, bsy);
      check($sformatf("rnd%0d_op%0d_%h_%h_res", t, op, a, b), r, er);
      check($sformatf("rnd%0d_flags", t), f, ef);
      check($sformatf("rnd%0d_lat", t), lat, LAT32);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
